// File: rtl/bus_bridge.sv
// CPU-to-bus bridge: latches one CPU transfer, waits for bus completion or timeout,
// then holds ready/error until the CPU drops its request.
module bus_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_cpu_rw,
    input  logic                      i_cpu_request,
    output logic                      o_cpu_ready,
    output logic                      o_cpu_error,
    input  logic [ADDR_WIDTH-1:0]     i_cpu_address,
    input  logic [DATA_WIDTH-1:0]     i_cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_cpu_wmask,
    output logic [DATA_WIDTH-1:0]     o_cpu_rdata,
    output logic                      o_bus_rw,
    output logic                      o_bus_request,
    input  logic                      i_bus_ready,
    output logic [ADDR_WIDTH-1:0]     o_bus_address,
    output logic [DATA_WIDTH-1:0]     o_bus_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_bus_wmask,
    input  logic [DATA_WIDTH-1:0]     i_bus_rdata,
    output logic [CNT_WIDTH-1:0]      o_timeout_count
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                  state, state_next;
    logic [CNT_WIDTH-1:0]    cnt, cnt_next;
    logic                    cpu_ready_next;
    logic                    cpu_error_next;
    logic [DATA_WIDTH-1:0]   cpu_rdata_next;
    logic                    bus_rw_next;
    logic                    bus_request_next;
    logic [ADDR_WIDTH-1:0]   bus_address_next;
    logic [DATA_WIDTH-1:0]   bus_wdata_next;
    logic [MASK_WIDTH-1:0]   bus_wmask_next;
    logic [CNT_WIDTH-1:0]    timeout_count_next;
    logic                    timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    always_comb begin
        state_next         = state;
        cnt_next           = cnt;
        cpu_ready_next     = o_cpu_ready;
        cpu_error_next     = o_cpu_error;
        cpu_rdata_next     = o_cpu_rdata;
        bus_rw_next        = o_bus_rw;
        bus_request_next   = o_bus_request;
        bus_address_next   = o_bus_address;
        bus_wdata_next     = o_bus_wdata;
        bus_wmask_next     = o_bus_wmask;
        timeout_count_next = o_timeout_count;

        case (state)
            IDLE: begin
                if (i_cpu_request) begin
                    bus_rw_next      = i_cpu_rw;
                    bus_address_next = i_cpu_address;
                    bus_wdata_next   = i_cpu_wdata;
                    bus_wmask_next   = i_cpu_wmask;
                    bus_request_next = 1'b1;
                    cnt_next         = '0;
                    state_next       = WAIT;
                end
            end
            WAIT: begin
                // a completion arriving on the timeout edge wins over the abort
                if (i_bus_ready) begin
                    if (!o_bus_rw) begin
                        cpu_rdata_next = i_bus_rdata;
                    end
                    bus_request_next = 1'b0;
                    cpu_ready_next   = 1'b1;
                    cpu_error_next   = 1'b0;
                    state_next       = DONE;
                end else if (timeout_hit) begin
                    bus_request_next = 1'b0;
                    cpu_ready_next   = 1'b1;
                    cpu_error_next   = 1'b1;
                    cpu_rdata_next   = '1;
                    if (o_timeout_count != '1) begin
                        timeout_count_next = o_timeout_count + CNT_WIDTH'(1);
                    end
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
            DONE: begin
                if (!i_cpu_request) begin
                    cpu_ready_next = 1'b0;
                    cpu_error_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state           <= IDLE;
            cnt             <= '0;
            o_cpu_ready     <= 1'b0;
            o_cpu_error     <= 1'b0;
            o_cpu_rdata     <= '0;
            o_bus_rw        <= 1'b0;
            o_bus_request   <= 1'b0;
            o_bus_address   <= '0;
            o_bus_wdata     <= '0;
            o_bus_wmask     <= '0;
            o_timeout_count <= '0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            o_cpu_ready     <= cpu_ready_next;
            o_cpu_error     <= cpu_error_next;
            o_cpu_rdata     <= cpu_rdata_next;
            o_bus_rw        <= bus_rw_next;
            o_bus_request   <= bus_request_next;
            o_bus_address   <= bus_address_next;
            o_bus_wdata     <= bus_wdata_next;
            o_bus_wmask     <= bus_wmask_next;
            o_timeout_count <= timeout_count_next;
        end
    end

endmodule

// File: tb/tb_bus_bridge.sv
// Directed bench for bus_bridge: a default-timeout instance and a TIMEOUT=4 instance
// share stimulus; completed transfers are checked against a queue of expected results.
module tb_bus_bridge;

    logic        clk;
    logic        rst_n;
    logic        rw;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    logic        d_ready, d_error, d_bus_rw, d_bus_req;
    logic [31:0] d_rdata, d_bus_addr, d_bus_wdata;
    logic [3:0]  d_bus_wmask;
    logic [7:0]  d_tcount;

    logic        t_ready, t_error, t_bus_rw, t_bus_req;
    logic [31:0] t_rdata, t_bus_addr, t_bus_wdata;
    logic [3:0]  t_bus_wmask;
    logic [7:0]  t_tcount;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bus_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT(255),
        .CNT_WIDTH(8)
    ) u_dut (
        .i_clock(clk), .i_reset(rst_n), .i_cpu_rw(rw), .i_cpu_request(req),
        .o_cpu_ready(d_ready), .o_cpu_error(d_error),
        .i_cpu_address(addr), .i_cpu_wdata(wdata), .i_cpu_wmask(wmask),
        .o_cpu_rdata(d_rdata), .o_bus_rw(d_bus_rw), .o_bus_request(d_bus_req),
        .i_bus_ready(bus_ready), .o_bus_address(d_bus_addr), .o_bus_wdata(d_bus_wdata),
        .o_bus_wmask(d_bus_wmask), .i_bus_rdata(bus_rdata), .o_timeout_count(d_tcount)
    );

    bus_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT(4),
        .CNT_WIDTH(8)
    ) u_dut_to (
        .i_clock(clk), .i_reset(rst_n), .i_cpu_rw(rw), .i_cpu_request(req),
        .o_cpu_ready(t_ready), .o_cpu_error(t_error),
        .i_cpu_address(addr), .i_cpu_wdata(wdata), .i_cpu_wmask(wmask),
        .o_cpu_rdata(t_rdata), .o_bus_rw(t_bus_rw), .o_bus_request(t_bus_req),
        .i_bus_ready(bus_ready), .o_bus_address(t_bus_addr), .o_bus_wdata(t_bus_wdata),
        .o_bus_wmask(t_bus_wmask), .i_bus_rdata(bus_rdata), .o_timeout_count(t_tcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_compare(input string tag, input logic [31:0] obs_rdata, input logic obs_err);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_rdata"}, obs_rdata, e.rdata);
            check({tag, "_error"}, 32'(obs_err), 32'(e.error));
        end
    endtask

    task automatic check_d_zero(input string tag);
        check({tag, "_ready"},   32'(d_ready), 32'd0);
        check({tag, "_error"},   32'(d_error), 32'd0);
        check({tag, "_bus_req"}, 32'(d_bus_req), 32'd0);
        check({tag, "_bus_rw"},  32'(d_bus_rw), 32'd0);
        check({tag, "_bus_addr"}, d_bus_addr, 32'd0);
        check({tag, "_bus_wdata"}, d_bus_wdata, 32'd0);
        check({tag, "_bus_wmask"}, 32'(d_bus_wmask), 32'd0);
        check({tag, "_rdata"},   d_rdata, 32'd0);
        check({tag, "_tcount"},  32'(d_tcount), 32'd0);
    endtask

    initial begin
        int hi;
        rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; wmask = '0;
        bus_ready = 1'b0; bus_rdata = '0;

        #2;
        check_d_zero("reset");
        @(negedge clk);
        @(negedge clk);

        // Read, bus ready in the first WAIT cycle; request presented with reset release
        rst_n = 1'b1;
        rw = 1'b0; addr = 32'h40; req = 1'b1; bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
        sb.push_back('{32'hDEADBEEF, 1'b0});
        @(negedge clk);
        check("s1_bus_req_rise", 32'(d_bus_req), 32'd1);
        check("s1_ready_early", 32'(d_ready), 32'd0);
        check("s1_bus_addr", d_bus_addr, 32'h40);
        @(negedge clk);
        check("s1_ready", 32'(d_ready), 32'd1);
        check("s1_bus_req_fall", 32'(d_bus_req), 32'd0);
        pop_compare("s1", d_rdata, d_error);
        req = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        check("s1_idle_ready", 32'(d_ready), 32'd0);

        // Write, ready after 5 WAIT cycles; CPU inputs scrambled while waiting
        rw = 1'b1; addr = 32'h100; wdata = 32'h12345678; wmask = 4'b0011; req = 1'b1;
        bus_rdata = 32'hA5A5A5A5;
        sb.push_back('{32'hDEADBEEF, 1'b0});
        @(negedge clk);
        rw = 1'b0; addr = 32'hFFFF0000; wdata = '0; wmask = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check("s2_bus_req", 32'(d_bus_req), 32'd1);
            check("s2_ready", 32'(d_ready), 32'd0);
            check("s2_bus_rw", 32'(d_bus_rw), 32'd1);
            check("s2_bus_addr", d_bus_addr, 32'h100);
            check("s2_bus_wdata", d_bus_wdata, 32'h12345678);
            check("s2_bus_wmask", 32'(d_bus_wmask), 32'h3);
            if (i == 4) bus_ready = 1'b1;
            @(negedge clk);
        end
        check("s2_done_ready", 32'(d_ready), 32'd1);
        check("s2_done_bus_req", 32'(d_bus_req), 32'd0);
        pop_compare("s2", d_rdata, d_error);
        req = 1'b0; bus_ready = 1'b0;
        @(negedge clk);

        // Read, then CPU holds request 3 cycles past ready; bus_ready left high in DONE
        rw = 1'b0; addr = 32'h200; bus_rdata = 32'h600DCAFE; bus_ready = 1'b1; req = 1'b1;
        sb.push_back('{32'h600DCAFE, 1'b0});
        @(negedge clk);
        @(negedge clk);
        check("s5_ready", 32'(d_ready), 32'd1);
        pop_compare("s5", d_rdata, d_error);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s5_hold_ready", 32'(d_ready), 32'd1);
            check("s5_hold_no_bus_req", 32'(d_bus_req), 32'd0);
        end
        req = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        check("s5_release_ready", 32'(d_ready), 32'd0);
        check("s5_release_error", 32'(d_error), 32'd0);

        // New read right away, then asynchronous reset while in WAIT
        addr = 32'h300; req = 1'b1;
        @(negedge clk);
        check("s6_bus_req", 32'(d_bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_d_zero("s6_async_reset");
        @(negedge clk);
        rst_n = 1'b1; bus_ready = 1'b1; bus_rdata = 32'h13579BDF;
        sb.push_back('{32'h13579BDF, 1'b0});
        @(negedge clk);
        check("s6_post_bus_req", 32'(d_bus_req), 32'd1);
        @(negedge clk);
        check("s6_post_ready", 32'(d_ready), 32'd1);
        pop_compare("s6", d_rdata, d_error);
        check("s6_post_tcount", 32'(d_tcount), 32'd0);
        req = 1'b0; bus_ready = 1'b0;
        @(negedge clk);

        // TIMEOUT=4 instance, bus never ready
        addr = 32'h400; req = 1'b1; bus_rdata = 32'h0;
        sb.push_back('{32'hFFFFFFFF, 1'b1});
        hi = 0;
        for (int i = 0; i < 10 && !t_ready; i++) begin
            @(negedge clk);
            if (t_bus_req) hi++;
        end
        check("s3_ready_within_bound", 32'(t_ready), 32'd1);
        check("s3_bus_req_cycles", 32'(hi), 32'd4);
        check("s3_bus_req_low", 32'(t_bus_req), 32'd0);
        pop_compare("s3", t_rdata, t_error);
        check("s3_tcount", 32'(t_tcount), 32'd1);
        req = 1'b0;
        @(negedge clk);
        check("s3_release_error", 32'(t_error), 32'd0);

        // TIMEOUT=4 instance, bus ready exactly on the timeout edge
        addr = 32'h500; req = 1'b1; bus_ready = 1'b0; bus_rdata = 32'h0BADF00D;
        sb.push_back('{32'h0BADF00D, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s4_bus_req", 32'(t_bus_req), 32'd1);
        end
        @(negedge clk);
        check("s4_bus_req_last", 32'(t_bus_req), 32'd1);
        check("s4_not_timed_out", 32'(t_ready), 32'd0);
        bus_ready = 1'b1;
        @(negedge clk);
        check("s4_ready", 32'(t_ready), 32'd1);
        pop_compare("s4", t_rdata, t_error);
        check("s4_tcount", 32'(t_tcount), 32'd1);
        req = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        check("s4_release_ready", 32'(t_ready), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_bridge.md
BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of the address path.
REQ-002 Parameter DATA_WIDTH, default 32, width of the data path; it SHALL be a multiple of 8.
REQ-003 Parameter TIMEOUT, default 255, the number of WAIT cycles before an abort; value 0 SHALL disable the timeout.
REQ-004 Parameter CNT_WIDTH, default 8, width of the timeout counter and of o_timeout_count; it SHALL satisfy 2^CNT_WIDTH > TIMEOUT.
REQ-005 i_clock, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-006 i_reset, input, 1: asynchronous, active-low reset.
REQ-007 i_cpu_rw, input, 1: 1 = write, 0 = read.
REQ-008 i_cpu_request, input, 1: CPU transfer request, level, held until o_cpu_ready.
REQ-009 o_cpu_ready, output, 1: registered transfer-complete indication to the CPU.
REQ-010 o_cpu_error, output, 1: transfer ended by timeout; valid while o_cpu_ready=1.
REQ-011 i_cpu_address, input, ADDR_WIDTH: CPU address.
REQ-012 i_cpu_wdata, input, DATA_WIDTH: CPU write data.
REQ-013 i_cpu_wmask, input, DATA_WIDTH/8: CPU byte write enables.
REQ-014 o_cpu_rdata, output, DATA_WIDTH: registered read data to the CPU.
REQ-015 o_bus_rw, output, 1: latched rw to the bus.
REQ-016 o_bus_request, output, 1: registered bus request.
REQ-017 i_bus_ready, input, 1: bus completion strobe.
REQ-018 o_bus_address, output, ADDR_WIDTH: latched address to the bus.
REQ-019 o_bus_wdata, output, DATA_WIDTH: latched write data to the bus.
REQ-020 o_bus_wmask, output, DATA_WIDTH/8: latched byte enables to the bus.
REQ-021 i_bus_rdata, input, DATA_WIDTH: bus read data.
REQ-022 o_timeout_count, output, CNT_WIDTH: saturating count of timed-out transfers.

Function
REQ-023 The bridge SHALL implement a three-state FSM with states IDLE, WAIT and DONE.
REQ-024 In IDLE with i_cpu_request=1 at an edge, the bridge SHALL latch rw, address, wdata and wmask, set o_bus_request=1, clear the timeout counter, and go to WAIT.
REQ-025 o_bus_request SHALL therefore rise exactly one cycle after the request is sampled.
REQ-026 CPU inputs SHALL be ignored outside IDLE, and the o_bus_* outputs SHALL remain stable throughout WAIT.
REQ-027 In WAIT with i_bus_ready=1 at an edge, the bridge SHALL:
- capture i_bus_rdata into o_cpu_rdata for a read, or leave o_cpu_rdata unchanged for a write;
- clear o_bus_request, set o_cpu_ready=1 and o_cpu_error=0;
- go to DONE.
REQ-028 i_bus_ready SHALL be ignored in IDLE and DONE.
REQ-029 In WAIT without i_bus_ready, the counter SHALL increment each cycle.
REQ-030 When TIMEOUT≠0 and the counter equals TIMEOUT-1 with i_bus_ready=0, the next edge SHALL:
- clear o_bus_request;
- set o_cpu_ready=1 and o_cpu_error=1;
- drive o_cpu_rdata to all ones;
- increment o_timeout_count, saturating at all ones;
- go to DONE.
REQ-031 If i_bus_ready=1 on the same edge as the timeout, a normal completion SHALL take priority.
REQ-032 In DONE, o_cpu_ready and o_cpu_error SHALL hold until i_cpu_request=0 is sampled.
REQ-033 On that edge the bridge SHALL clear both and return to IDLE, so back-to-back transfers require one request-low cycle.
REQ-034 Minimum latency from request sampled to o_cpu_ready high SHALL be 2 cycles, given i_bus_ready high in the first WAIT cycle.

Reset
REQ-035 While i_reset=0, independent of the clock, the bridge SHALL set:
- state=IDLE;
- o_cpu_ready, o_cpu_error, o_bus_request = 0;
- o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask, o_cpu_rdata = 0;
- timeout counter and o_timeout_count = 0.
REQ-036 A reset asserted mid-transfer SHALL abort the transfer immediately (o_bus_request=0) without counting a timeout.
REQ-037 After reset release, the first request SHALL be accepted on the first rising edge where i_reset=1 and i_cpu_request=1.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- Read, bus ready in first WAIT cycle, rdata=0xDEADBEEF -> o_bus_request high 1 cycle; o_cpu_ready high 2 cycles after request; o_cpu_rdata=0xDEADBEEF; error=0.
- Write addr=0x100, wdata=0x12345678, wmask=4'b0011, ready after 5 cycles -> bus outputs hold those values for all 5 WAIT cycles; o_cpu_ready then 1; o_cpu_rdata unchanged.
- TIMEOUT=4, bus never ready -> o_bus_request high exactly 4 cycles; o_cpu_ready=1, o_cpu_error=1, o_cpu_rdata=0xFFFFFFFF; o_timeout_count=1.
- TIMEOUT=4, i_bus_ready on 4th WAIT cycle -> normal completion; error=0; o_timeout_count unchanged.
- CPU holds request 3 cycles after ready -> o_cpu_ready stays high; no new o_bus_request; IDLE one cycle after request drops.
- i_reset=0 asynchronously during WAIT -> all outputs 0 before the next clock edge; after release, a new read completes normally.
